proc_io_bridge: RTL and testbench

Host-side I/O bridge for the 16-bit load/store processor. It drives the processor's read_in word from a host-loaded holding register with a valid/ready handshake. It also captures each word the processor writes on write_out into an output FIFO that the host drains with valid/ready. The bridge sits between the processor top level and the bench or host logic.

---
 rtl/proc_io_bridge_if.sv | 37 +++
 rtl/proc_io_bridge.sv | 108 ++++++++++
 tb/tb_proc_io_bridge.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/proc_io_bridge_if.sv
// Host/processor-side signal bundle for proc_io_bridge.
// slave  : the bridge (drives host_in_ready, proc_read_in, FIFO head, status)
// master : the host/bench (drives host words, processor pulses, host_out_ready)
interface proc_io_bridge_if #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] host_in_data;
   logic             host_in_valid;
   logic             host_in_ready;
   logic [WIDTH-1:0] proc_read_in;
   logic             proc_in_ack;
   logic [WIDTH-1:0] proc_write_out;
   logic             proc_out_strobe;
   logic [WIDTH-1:0] host_out_data;
   logic             host_out_valid;
   logic             host_out_ready;
   logic [CW-1:0]    out_count;
   logic             overflow;
   logic             underrun;

   modport slave (
      input  host_in_data, host_in_valid, proc_in_ack,
      input  proc_write_out, proc_out_strobe, host_out_ready,
      output host_in_ready, proc_read_in, host_out_data, host_out_valid,
      output out_count, overflow, underrun
   );

   modport master (
      output host_in_data, host_in_valid, proc_in_ack,
      output proc_write_out, proc_out_strobe, host_out_ready,
      input  host_in_ready, proc_read_in, host_out_data, host_out_valid,
      input  out_count, overflow, underrun
   );
endinterface

// File: rtl/proc_io_bridge.sv
// Host-side I/O bridge for the 16-bit load/store processor.
// Input path : one-word holding register feeding proc_read_in, loaded by a
//              host valid/ready handshake and freed by proc_in_ack.
// Output path: show-ahead FIFO capturing proc_write_out on proc_out_strobe,
//              drained by the host with valid/ready.
// Ports: clock, rst (async, active-high), bus (proc_io_bridge_if.slave).
//
// state   | meaning
// --------+-------------------------------------------
// S_EMPTY | holding register free, host_in_ready=1
// S_FULL  | word presented on proc_read_in, awaiting ack
module proc_io_bridge #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input logic          clock,
   input logic          rst,
   proc_io_bridge_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic {S_EMPTY, S_FULL} in_state_t;

   in_state_t state, state_next;
   logic      load;
   logic      ack_empty;

   always_comb begin
      state_next = state;
      load       = 1'b0;
      ack_empty  = 1'b0;
      case (state)
         S_EMPTY: begin
            ack_empty = bus.proc_in_ack;
            if (bus.host_in_valid) begin
               load       = 1'b1;
               state_next = S_FULL;
            end
         end
         S_FULL: begin
            if (bus.proc_in_ack) state_next = S_EMPTY;
         end
         default: state_next = S_EMPTY;
      endcase
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state             <= S_EMPTY;
         bus.host_in_ready <= 1'b1;
         bus.proc_read_in  <= '0;
         bus.underrun      <= 1'b0;
      end else begin
         state             <= state_next;
         bus.host_in_ready <= (state_next == S_EMPTY);
         if (load)      bus.proc_read_in <= bus.host_in_data;
         if (ack_empty) bus.underrun     <= 1'b1;
      end
   end

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr, rd_next;
   logic [CW-1:0]    cnt, cnt_next;
   logic             full, push, pop;

   assign full           = (cnt == CW'(DEPTH));
   assign bus.host_out_valid = (cnt != '0);
   assign bus.out_count  = cnt;
   // A pop while full frees a slot in the same cycle, so the strobe is kept.
   assign pop  = bus.host_out_valid && bus.host_out_ready;
   assign push = bus.proc_out_strobe && (!full || pop);
   assign rd_next = pop ? rd_ptr + AW'(1) : rd_ptr;

   always_comb begin
      cnt_next = cnt;
      case ({push, pop})
         2'b10:   cnt_next = cnt + CW'(1);
         2'b01:   cnt_next = cnt - CW'(1);
         default: cnt_next = cnt;
      endcase
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         wr_ptr            <= '0;
         rd_ptr            <= '0;
         cnt               <= '0;
         bus.host_out_data <= '0;
         bus.overflow      <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= bus.proc_write_out;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         rd_ptr <= rd_next;
         cnt    <= cnt_next;
         // Registered head: the incoming word becomes the head when it lands
         // on the next read slot; an emptied FIFO keeps the last popped word.
         if (push && (wr_ptr == rd_next))
            bus.host_out_data <= bus.proc_write_out;
         else if (cnt_next != '0)
            bus.host_out_data <= mem[rd_next];
         if (bus.proc_out_strobe && full && !pop) bus.overflow <= 1'b1;
      end
   end
endmodule

// File: tb/tb_proc_io_bridge.sv
module tb_proc_io_bridge;
   logic clock = 1'b0;
   logic rst   = 1'b1;
   int   total = 0;
   int   fails = 0;

   always #5 clock = ~clock;

   proc_io_bridge_if #(.WIDTH(16), .DEPTH(4)) bus ();

   proc_io_bridge #(.WIDTH(16), .DEPTH(4)) dut (
      .clock (clock),
      .rst   (rst),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input logic [15:0] w);
      bus.proc_write_out  = w;
      bus.proc_out_strobe = 1'b1;
      tick();
      bus.proc_out_strobe = 1'b0;
   endtask

   task automatic pop_chk(input string tag, input logic [15:0] exp);
      chk({tag, "_valid"}, 32'(bus.host_out_valid), 32'd1);
      chk({tag, "_data"}, 32'(bus.host_out_data), 32'(exp));
      bus.host_out_ready = 1'b1;
      tick();
      bus.host_out_ready = 1'b0;
   endtask

   initial begin
      bus.host_in_data    = '0;
      bus.host_in_valid   = 1'b0;
      bus.proc_in_ack     = 1'b0;
      bus.proc_write_out  = '0;
      bus.proc_out_strobe = 1'b0;
      bus.host_out_ready  = 1'b0;

      // reset state
      tick(); tick();
      chk("rst_in_ready", 32'(bus.host_in_ready), 32'd1);
      chk("rst_read_in", 32'(bus.proc_read_in), 32'd0);
      chk("rst_count", 32'(bus.out_count), 32'd0);
      chk("rst_out_valid", 32'(bus.host_out_valid), 32'd0);
      chk("rst_out_data", 32'(bus.host_out_data), 32'd0);
      chk("rst_overflow", 32'(bus.overflow), 32'd0);
      chk("rst_underrun", 32'(bus.underrun), 32'd0);
      rst = 1'b0;
      tick();

      // input handshake
      bus.host_in_data  = 16'h13b0;
      bus.host_in_valid = 1'b1;
      tick();
      bus.host_in_valid = 1'b0;
      chk("hs_read_in", 32'(bus.proc_read_in), 32'h13b0);
      chk("hs_ready_low", 32'(bus.host_in_ready), 32'd0);
      bus.proc_in_ack = 1'b1;
      tick();
      bus.proc_in_ack = 1'b0;
      chk("ack_ready", 32'(bus.host_in_ready), 32'd1);
      chk("ack_read_in_kept", 32'(bus.proc_read_in), 32'h13b0);
      chk("ack_no_underrun", 32'(bus.underrun), 32'd0);

      // underrun, then async reset without a clock edge
      bus.proc_in_ack = 1'b1;
      tick();
      bus.proc_in_ack = 1'b0;
      chk("ur_flag", 32'(bus.underrun), 32'd1);
      chk("ur_read_in", 32'(bus.proc_read_in), 32'h13b0);
      rst = 1'b1;
      #1;
      chk("ur_rst_flag", 32'(bus.underrun), 32'd0);
      chk("ur_rst_read_in", 32'(bus.proc_read_in), 32'd0);
      rst = 1'b0;
      tick();

      // ack in EMPTY together with a load: load wins, ack not applied
      bus.host_in_data  = 16'h5a5a;
      bus.host_in_valid = 1'b1;
      bus.proc_in_ack   = 1'b1;
      tick();
      bus.host_in_valid = 1'b0;
      bus.proc_in_ack   = 1'b0;
      chk("ul_underrun", 32'(bus.underrun), 32'd1);
      chk("ul_read_in", 32'(bus.proc_read_in), 32'h5a5a);
      chk("ul_ready", 32'(bus.host_in_ready), 32'd0);
      bus.proc_in_ack = 1'b1;
      tick();
      bus.proc_in_ack = 1'b0;
      chk("ul_ack_ready", 32'(bus.host_in_ready), 32'd1);

      // FIFO order and wrap
      push(16'h000b); push(16'h0003); push(16'h1234); push(16'hffff);
      chk("fifo_count4", 32'(bus.out_count), 32'd4);
      pop_chk("pop0", 16'h000b);
      pop_chk("pop1", 16'h0003);
      chk("fifo_count2", 32'(bus.out_count), 32'd2);
      push(16'h0001); push(16'h0002);
      chk("wrap_count4", 32'(bus.out_count), 32'd4);
      pop_chk("pop2", 16'h1234);
      pop_chk("pop3", 16'hffff);
      pop_chk("pop4", 16'h0001);
      pop_chk("pop5", 16'h0002);
      chk("drain_count", 32'(bus.out_count), 32'd0);
      chk("drain_valid", 32'(bus.host_out_valid), 32'd0);
      bus.host_out_ready = 1'b1;
      tick();
      bus.host_out_ready = 1'b0;
      chk("empty_ready_count", 32'(bus.out_count), 32'd0);
      chk("no_overflow_yet", 32'(bus.overflow), 32'd0);

      // overflow
      push(16'h00a1); push(16'h00a2); push(16'h00a3); push(16'h00a4);
      push(16'hdead);
      chk("ovf_flag", 32'(bus.overflow), 32'd1);
      chk("ovf_count", 32'(bus.out_count), 32'd4);
      chk("ovf_head", 32'(bus.host_out_data), 32'h00a1);
      // push and pop together while full
      bus.proc_write_out  = 16'hbeef;
      bus.proc_out_strobe = 1'b1;
      bus.host_out_ready  = 1'b1;
      tick();
      bus.proc_out_strobe = 1'b0;
      bus.host_out_ready  = 1'b0;
      chk("fullpp_count", 32'(bus.out_count), 32'd4);
      pop_chk("ovf_pop0", 16'h00a2);
      pop_chk("ovf_pop1", 16'h00a3);
      pop_chk("ovf_pop2", 16'h00a4);
      pop_chk("ovf_pop3", 16'hbeef);
      chk("ovf_drain_count", 32'(bus.out_count), 32'd0);

      // simultaneous push/pop at count=1
      push(16'h0005);
      chk("pp1_count", 32'(bus.out_count), 32'd1);
      chk("pp1_head", 32'(bus.host_out_data), 32'h0005);
      bus.proc_write_out  = 16'h0006;
      bus.proc_out_strobe = 1'b1;
      bus.host_out_ready  = 1'b1;
      tick();
      bus.proc_out_strobe = 1'b0;
      bus.host_out_ready  = 1'b0;
      chk("pp1_count_after", 32'(bus.out_count), 32'd1);
      pop_chk("pp1_pop", 16'h0006);

      // push and pop together when empty: pop ignored
      bus.proc_write_out  = 16'h0007;
      bus.proc_out_strobe = 1'b1;
      bus.host_out_ready  = 1'b1;
      tick();
      bus.proc_out_strobe = 1'b0;
      bus.host_out_ready  = 1'b0;
      chk("pp0_count", 32'(bus.out_count), 32'd1);
      pop_chk("pp0_pop", 16'h0007);

      // async reset mid-transfer
      push(16'h0011); push(16'h0022); push(16'h0033);
      bus.host_in_data  = 16'h7777;
      bus.host_in_valid = 1'b1;
      tick();
      bus.host_in_valid = 1'b0;
      chk("mid_count3", 32'(bus.out_count), 32'd3);
      chk("mid_ready_low", 32'(bus.host_in_ready), 32'd0);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_count", 32'(bus.out_count), 32'd0);
      chk("mid_rst_valid", 32'(bus.host_out_valid), 32'd0);
      chk("mid_rst_ready", 32'(bus.host_in_ready), 32'd1);
      chk("mid_rst_overflow", 32'(bus.overflow), 32'd0);
      chk("mid_rst_read_in", 32'(bus.proc_read_in), 32'd0);
      #1;
      rst = 1'b0;
      tick();
      push(16'h00aa);
      chk("post_rst_valid", 32'(bus.host_out_valid), 32'd1);
      chk("post_rst_head", 32'(bus.host_out_data), 32'h00aa);
      chk("post_rst_count", 32'(bus.out_count), 32'd1);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end
endmodule
